reset_source: RTL and testbench

RESET_SOURCE -- requirements
Module: reset_source

---
 rtl/reset_source.sv | 187 ++++++++++++++++++
 tb/tb_reset_source.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/reset_source.sv
// reset_source: system reset request generator.
//
// Combines a power-on hold, a debounced reset push-button and an optional
// watchdog into a single registered active-low reset request that feeds the
// reset block's _RESET_SWITCH input.
//
// Optional feature macro: RESET_SOURCE_WDT_EN
//   defined   -> watchdog counter compiled in (cause 11 possible)
//   undefined -> no watchdog; _wdt_kick and wdt_enable are ignored
//
// Ports:
//   system_clk  in   sole clock, rising edge
//   mr          in   synchronous active-high master reset
//   _button     in   raw active-low reset switch
//   _wdt_kick   in   active-low watchdog kick strobe
//   wdt_enable  in   watchdog enable
//   _reset_out  out  registered active-low reset request
//   cause       out  last reset cause: 01 POR, 10 BUTTON, 11 WDT
//   busy        out  high whenever the FSM is not in RUN
//
// State table:
//   state     | meaning
//   POR_HOLD  | power-on / master-reset hold, counting POR_CYCLES edges
//   RUN       | reset released; debounce button, run watchdog
//   ASSERT    | reset pulse; at least PULSE_CYCLES edges, until button released

module reset_source #(
    parameter int POR_CYCLES   = 4,
    parameter int DEBOUNCE     = 3,
    parameter int WDT_CYCLES   = 256,
    parameter int PULSE_CYCLES = 4
) (
    input  logic       system_clk,
    input  logic       mr,
    input  logic       _button,
    input  logic       _wdt_kick,
    input  logic       wdt_enable,
    output logic       _reset_out,
    output logic [1:0] cause,
    output logic       busy
);

    typedef enum logic [1:0] {
        POR_HOLD = 2'd0,
        RUN      = 2'd1,
        ASSERT   = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_POR    = 2'b01;
    localparam logic [1:0] CAUSE_BUTTON = 2'b10;
    localparam logic [1:0] CAUSE_WDT    = 2'b11;

    localparam int POR_W   = $clog2(POR_CYCLES + 1);
    localparam int DEB_W   = $clog2(DEBOUNCE + 1);
    localparam int PULSE_W = $clog2(PULSE_CYCLES + 1);

    localparam logic [POR_W-1:0]   POR_LAST   = POR_W'(POR_CYCLES - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE - 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_CYCLES - 1);
    localparam logic [PULSE_W-1:0] PULSE_MAX  = PULSE_W'(PULSE_CYCLES);

    state_t               state, state_nxt;
    logic [POR_W-1:0]     por_cnt, por_nxt;
    logic [DEB_W-1:0]     deb_cnt, deb_nxt;
    logic [PULSE_W-1:0]   pulse_cnt, pulse_nxt;
    logic [1:0]           cause_nxt;
    logic                 btn_fire;
    logic                 wdt_fire;

`ifdef RESET_SOURCE_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0]     wdt_cnt, wdt_nxt;
`else
    // Watchdog inputs have no function in this build.
    logic unused_wdt_inputs;
    assign unused_wdt_inputs = _wdt_kick ^ wdt_enable;
`endif

    always_comb begin
        state_nxt = state;
        por_nxt   = por_cnt;
        deb_nxt   = deb_cnt;
        pulse_nxt = pulse_cnt;
        cause_nxt = cause;
        btn_fire  = 1'b0;
        wdt_fire  = 1'b0;
`ifdef RESET_SOURCE_WDT_EN
        wdt_nxt   = wdt_cnt;
`endif

        case (state)
            POR_HOLD: begin
                if (por_cnt == POR_LAST) begin
                    state_nxt = RUN;
                end else begin
                    por_nxt = por_cnt + POR_W'(1);
                end
            end

            RUN: begin
                if (!_button) begin
                    if (deb_cnt == DEB_LAST) begin
                        btn_fire = 1'b1;
                    end else begin
                        deb_nxt = deb_cnt + DEB_W'(1);
                    end
                end else begin
                    deb_nxt = '0;
                end

`ifdef RESET_SOURCE_WDT_EN
                if (wdt_enable && _wdt_kick) begin
                    if (wdt_cnt == WDT_LAST) begin
                        wdt_fire = 1'b1;
                    end else begin
                        wdt_nxt = wdt_cnt + WDT_W'(1);
                    end
                end else begin
                    wdt_nxt = '0;
                end
`endif

                // Button has priority when both events land on the same edge.
                if (btn_fire) begin
                    state_nxt = ASSERT;
                    cause_nxt = CAUSE_BUTTON;
                end else if (wdt_fire) begin
                    state_nxt = ASSERT;
                    cause_nxt = CAUSE_WDT;
                end
            end

            ASSERT: begin
                // pulse_cnt + 1 is the edge count including this edge; it
                // saturates so a held button never wraps it.
                if ((pulse_cnt >= PULSE_LAST) && _button) begin
                    state_nxt = RUN;
                end else if (pulse_cnt != PULSE_MAX) begin
                    pulse_nxt = pulse_cnt + PULSE_W'(1);
                end
            end

            default: begin
                state_nxt = POR_HOLD;
            end
        endcase

        // Every state entry starts all timers from zero.
        if (state_nxt != state) begin
            por_nxt   = '0;
            deb_nxt   = '0;
            pulse_nxt = '0;
`ifdef RESET_SOURCE_WDT_EN
            wdt_nxt   = '0;
`endif
        end
    end

    always_ff @(posedge system_clk) begin
        if (mr) begin
            state      <= POR_HOLD;
            por_cnt    <= '0;
            deb_cnt    <= '0;
            pulse_cnt  <= '0;
            _reset_out <= 1'b0;
            cause      <= CAUSE_POR;
            busy       <= 1'b1;
`ifdef RESET_SOURCE_WDT_EN
            wdt_cnt    <= '0;
`endif
        end else begin
            state      <= state_nxt;
            por_cnt    <= por_nxt;
            deb_cnt    <= deb_nxt;
            pulse_cnt  <= pulse_nxt;
            _reset_out <= (state_nxt == RUN);
            cause      <= cause_nxt;
            busy       <= (state_nxt != RUN);
`ifdef RESET_SOURCE_WDT_EN
            wdt_cnt    <= wdt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_reset_source.sv
module tb_reset_source;

    localparam int POR   = 4;
    localparam int DEB   = 3;
    localparam int WDT   = 8;
    localparam int PULSE = 4;

`ifdef RESET_SOURCE_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic       system_clk = 1'b0;
    logic       mr = 1'b1;
    logic       _button = 1'b1;
    logic       _wdt_kick = 1'b1;
    logic       wdt_enable = 1'b0;
    logic       _reset_out;
    logic [1:0] cause;
    logic       busy;

    reset_source #(
        .POR_CYCLES  (POR),
        .DEBOUNCE    (DEB),
        .WDT_CYCLES  (WDT),
        .PULSE_CYCLES(PULSE)
    ) dut (
        .system_clk(system_clk),
        .mr        (mr),
        ._button   (_button),
        ._wdt_kick (_wdt_kick),
        .wdt_enable(wdt_enable),
        ._reset_out(_reset_out),
        .cause     (cause),
        .busy      (busy)
    );

    always #5 system_clk = ~system_clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [3:0] exp_q[$];

    // Reference model: "where are we in the reset story" expressed as
    // a mode plus plain integer tallies of recent input history.
    typedef enum int { M_POR, M_RUN, M_PULSE } mode_t;
    mode_t      m_mode = M_POR;
    int         m_por_seen;
    int         m_lows;
    int         m_idle;
    int         m_pulse;
    logic [1:0] m_cause = 2'b01;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_edge(input logic m, input logic b, input logic k, input logic e);
        if (m) begin
            m_mode = M_POR; m_por_seen = 0; m_lows = 0; m_idle = 0; m_pulse = 0;
            m_cause = 2'b01;
        end else begin
            case (m_mode)
                M_POR: begin
                    m_por_seen++;
                    if (m_por_seen >= POR) begin
                        m_mode = M_RUN; m_lows = 0; m_idle = 0;
                    end
                end
                M_RUN: begin
                    m_lows = b ? 0 : m_lows + 1;
                    m_idle = (WDT_ON && e && k) ? m_idle + 1 : 0;
                    if (m_lows >= DEB) begin
                        m_mode = M_PULSE; m_pulse = 0; m_cause = 2'b10;
                    end else if (WDT_ON && m_idle >= WDT) begin
                        m_mode = M_PULSE; m_pulse = 0; m_cause = 2'b11;
                    end
                end
                default: begin
                    m_pulse++;
                    if (m_pulse >= PULSE && b) begin
                        m_mode = M_RUN; m_lows = 0; m_idle = 0;
                    end
                end
            endcase
        end
    endtask

    // Applies inputs for exactly one rising edge and queues the expected result.
    task automatic step(input logic m, input logic b, input logic k, input logic e);
        @(negedge system_clk);
        mr = m; _button = b; _wdt_kick = k; wdt_enable = e;
        model_edge(m, b, k, e);
        exp_q.push_back({(m_mode == M_RUN), m_cause, (m_mode != M_RUN)});
        @(posedge system_clk);
        #1;
    endtask

    initial begin : monitor
        logic [3:0] e;
        forever begin
            @(posedge system_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scoreboard", {_reset_out, cause, busy}, e);
            end
        end
    end

    initial begin : stim
        logic btn, kick, en, m;

        // Power-on hold
        step(1, 1, 1, 0);
        step(1, 1, 1, 0);
        check("por_mr_out", 4'(_reset_out), 4'd0);
        check("por_mr_cause", 4'(cause), 4'd1);
        check("por_mr_busy", 4'(busy), 4'd1);
        repeat (POR - 1) step(0, 1, 1, 0);
        check("por_before_release", 4'(_reset_out), 4'd0);
        step(0, 1, 1, 0);
        check("por_release_out", 4'(_reset_out), 4'd1);
        check("por_release_busy", 4'(busy), 4'd0);

        // Short press ignored, full press triggers
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        check("short_press", 4'(_reset_out), 4'd1);
        repeat (DEB) step(0, 0, 1, 0);
        check("press_out", 4'(_reset_out), 4'd0);
        check("press_cause", 4'(cause), 4'd2);
        repeat (PULSE - 1) step(0, 1, 1, 0);
        check("pulse_min_len", 4'(_reset_out), 4'd0);
        step(0, 1, 1, 0);
        check("pulse_release", 4'(_reset_out), 4'd1);

        // Held button
        repeat (10) step(0, 0, 1, 0);
        check("held_low", 4'(_reset_out), 4'd0);
        step(0, 1, 1, 0);
        check("held_release", 4'(_reset_out), 4'd1);
        repeat (3) step(0, 1, 1, 0);

        // Watchdog behaviour (or its absence)
        if (WDT_ON) begin
            repeat (WDT - 1) step(0, 1, 1, 1);
            check("wdt_before", 4'(_reset_out), 4'd1);
            step(0, 1, 1, 1);
            check("wdt_fire_out", 4'(_reset_out), 4'd0);
            check("wdt_fire_cause", 4'(cause), 4'd3);
            repeat (PULSE - 1) step(0, 1, 1, 1);
            check("wdt_pulse_len", 4'(_reset_out), 4'd0);
            step(0, 1, 1, 1);
            check("wdt_pulse_end", 4'(_reset_out), 4'd1);
            for (int i = 1; i <= 42; i++) step(0, 1, (i % 7) != 0, 1);
            check("wdt_kicked", 4'(_reset_out), 4'd1);
        end else begin
            repeat (100) step(0, 1, 1, 1);
            check("nowdt_out", 4'(_reset_out), 4'd1);
            check("nowdt_cause", 4'(cause), 4'd2);
        end
        step(0, 1, 1, 0);

        // Master reset in the middle of a pulse
        repeat (DEB) step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        step(1, 1, 1, 0);
        check("mr_mid_cause", 4'(cause), 4'd1);
        check("mr_mid_busy", 4'(busy), 4'd1);
        repeat (POR - 1) step(0, 1, 1, 0);
        check("mr_mid_hold", 4'(_reset_out), 4'd0);
        step(0, 1, 1, 0);
        check("mr_mid_release", 4'(_reset_out), 4'd1);

        // Button third low sample on the watchdog's eighth unkicked edge
        repeat (WDT - DEB) step(0, 1, 1, 1);
        repeat (DEB) step(0, 0, 1, 1);
        check("coincident_out", 4'(_reset_out), 4'd0);
        check("coincident_cause", 4'(cause), 4'd2);
        repeat (PULSE) step(0, 1, 1, 0);

        // Randomized traffic against the model
        btn = 1'b1; en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5, 0) == 0) btn = ~btn;
            if ($urandom_range(49, 0) == 0) en = ~en;
            kick = ($urandom_range(9, 0) != 0);
            m    = ($urandom_range(99, 0) == 0);
            step(m, btn, kick, en);
        end

        repeat (2) @(posedge system_clk);
        #2;
        check("queue_drained", 4'(exp_q.size() > 0), 4'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
